// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline defines: hold codes, sequencer states, NOP encoding.
// Consumed by pipe_hazard_ctrl and by the DFF_SET pipeline registers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD_NONE = 2'b00,
        HOLD_PC   = 2'b01,
        HOLD_IF   = 2'b10,
        HOLD_ID   = 2'b11
    } hold_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_JDRAIN   = 2'b10
    } state_e;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: stall/flush sources in, hold/redirect out.
// slave = sequencer side, master = pipeline side.
interface pipe_hazard_ctrl_if;

    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        load_use_i;
    logic        mem_req_i;
    logic        mem_done_i;
    logic        if_busy_i;
    logic        if_done_i;
    logic [1:0]  hold_flag_o;
    logic        flush_o;
    logic        jump_en_o;
    logic [63:0] jump_addr_o;
    logic        mem_err_o;

    modport slave (
        input  jump_en_i,
        input  jump_addr_i,
        input  load_use_i,
        input  mem_req_i,
        input  mem_done_i,
        input  if_busy_i,
        input  if_done_i,
        output hold_flag_o,
        output flush_o,
        output jump_en_o,
        output jump_addr_o,
        output mem_err_o
    );

    modport master (
        output jump_en_i,
        output jump_addr_i,
        output load_use_i,
        output mem_req_i,
        output mem_done_i,
        output if_busy_i,
        output if_done_i,
        input  hold_flag_o,
        input  flush_o,
        input  jump_en_o,
        input  jump_addr_o,
        input  mem_err_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hold_timeout_cnt.sv
// Memory-wait cycle counter with expiry compare.
// Instantiated only when PIPE_HAZARD_CTRL_TIMEOUT_EN is defined.
module hold_timeout_cnt #(
    parameter int TIMEOUT   = 256,
    parameter int TIMEOUT_W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;

    // Count wait cycles; clear on entry to the wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: merges redirect, load-use and memory stalls
// into one hold code. Optional timeout: PIPE_HAZARD_CTRL_TIMEOUT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 256,
    parameter int TIMEOUT_W = 9
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    if ((2 ** TIMEOUT_W) <= TIMEOUT) begin : g_bad_cfg
        $error("TIMEOUT_W too narrow for TIMEOUT");
    end

    state_e      state_q;
    state_e      state_d;
    logic [63:0] target_q;
    logic [63:0] target_d;
    hold_e       hold;
    logic        flush;
    logic        jump_en;
    logic        mem_err;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_inc;
    logic expired;

    hold_timeout_cnt #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );
`endif

    // State and redirect target registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            target_q <= ZERO_WORD;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state and Mealy outputs, in priority order per state.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        hold     = HOLD_NONE;
        flush    = 1'b0;
        jump_en  = 1'b0;
        mem_err  = 1'b0;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.jump_en_i && !bus.if_busy_i) begin
                    jump_en = 1'b1;
                    flush   = 1'b1;
                end else if (bus.jump_en_i) begin
                    target_d = bus.jump_addr_i;
                    flush    = 1'b1;
                    hold     = HOLD_PC;
                    state_d  = ST_JDRAIN;
                end else if (bus.mem_req_i && !bus.mem_done_i) begin
                    hold    = HOLD_ID;
                    state_d = ST_MEM_WAIT;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
                    cnt_clr = 1'b1;
`endif
                end else if (bus.mem_req_i) begin
                    hold = HOLD_NONE;
                end else if (bus.load_use_i) begin
                    hold = HOLD_IF;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_done_i) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
                    if (expired) begin
                        mem_err = 1'b1;
                        flush   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        hold    = HOLD_ID;
                        cnt_inc = 1'b1;
                    end
`else
                    hold = HOLD_ID;
`endif
                end
            end
            ST_JDRAIN: begin
                flush = 1'b1;
                hold  = HOLD_PC;
                if (bus.if_done_i) begin
                    jump_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        bus.hold_flag_o = HOLD_NONE;
        bus.flush_o     = 1'b0;
        bus.jump_en_o   = 1'b0;
        bus.jump_addr_o = ZERO_WORD;
        bus.mem_err_o   = 1'b0;
        if (rst) begin
            bus.hold_flag_o = hold;
            bus.flush_o     = flush;
            bus.jump_en_o   = jump_en;
            bus.mem_err_o   = mem_err;
            bus.jump_addr_o = (state_q == ST_IDLE) ? bus.jump_addr_i
                                                   : target_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Timeout scenario runs when PIPE_HAZARD_CTRL_TIMEOUT_EN is defined.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    typedef struct packed {
        logic        rst;
        logic        jen;
        logic [63:0] ja;
        logic        lu;
        logic        mreq;
        logic        mdone;
        logic        busy;
        logic        idone;
    } stim_t;

    typedef struct packed {
        logic [1:0]  hold;
        logic        flush;
        logic        jen;
        logic [63:0] ja;
        logic        err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ntests = 0;
    int   nfail = 0;
    obs_t sb[$];

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT   (TO),
        .TIMEOUT_W (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic r, logic j, logic [63:0] a,
                                logic l, logic mq, logic md,
                                logic b, logic d);
        S = '{rst: r, jen: j, ja: a, lu: l, mreq: mq,
              mdone: md, busy: b, idone: d};
    endfunction

    function automatic obs_t E(logic [1:0] h, logic f, logic j,
                               logic [63:0] a, logic e);
        E = '{hold: h, flush: f, jen: j, ja: a, err: e};
    endfunction

    function automatic obs_t observe();
        observe = '{hold: bus.hold_flag_o, flush: bus.flush_o,
                    jen: bus.jump_en_o, ja: bus.jump_addr_o,
                    err: bus.mem_err_o};
    endfunction

    task automatic apply(input stim_t s, input obs_t e);
        rst             = s.rst;
        bus.jump_en_i   = s.jen;
        bus.jump_addr_i = s.ja;
        bus.load_use_i  = s.lu;
        bus.mem_req_i   = s.mreq;
        bus.mem_done_i  = s.mdone;
        bus.if_busy_i   = s.busy;
        bus.if_done_i   = s.idone;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(0, 1, 64'h1234, 1, 1, 0, 1, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(0, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL reset[%0d] got %h want %h", i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 1, 0, 0, 0, 0));
        ex.push_back(E(2'b10, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL load_use[%0d] got %h want %h", i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        for (int c = 0; c < 4; c++) begin
            st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
            ex.push_back(E(2'b11, 0, 0, 64'h0, 0));
        end
        st.push_back(S(1, 0, 64'h0, 0, 1, 1, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 1, 0, 0, 0, 0));
        ex.push_back(E(2'b10, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL mem_wait[%0d] got %h want %h", i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump_conflict();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 1, 64'h8000_0040, 1, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 1, 1, 64'h8000_0040, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL jump_conflict[%0d] got %h want %h",
                         i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump_busy();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 1, 64'h8000_0040, 0, 0, 0, 1, 0));
        ex.push_back(E(2'b01, 1, 0, 64'h8000_0040, 0));
        st.push_back(S(1, 1, 64'hdead, 1, 1, 0, 1, 0));
        ex.push_back(E(2'b01, 1, 0, 64'h8000_0040, 0));
        st.push_back(S(1, 0, 64'hbeef, 0, 0, 0, 1, 0));
        ex.push_back(E(2'b01, 1, 0, 64'h8000_0040, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 1, 1));
        ex.push_back(E(2'b01, 1, 1, 64'h8000_0040, 0));
        st.push_back(S(1, 0, 64'h77, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h77, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL jump_busy[%0d] got %h want %h", i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 0, 64'h0, 1, 1, 1, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b11, 0, 0, 64'h0, 0));
        st.push_back(S(1, 1, 64'h55, 1, 1, 0, 0, 0));
        ex.push_back(E(2'b11, 0, 0, 64'h8000_0040, 0));
        st.push_back(S(1, 1, 64'h55, 0, 1, 1, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h8000_0040, 0));
        st.push_back(S(1, 1, 64'h100, 1, 1, 0, 0, 0));
        ex.push_back(E(2'b00, 1, 1, 64'h100, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL back_to_back[%0d] got %h want %h",
                         i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b11, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b11, 0, 0, 64'h8000_0040, 0));
        st.push_back(S(0, 1, 64'h99, 1, 1, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 0));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 1, 0, 0, 0, 0));
        ex.push_back(E(2'b10, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL reset_mid_wait[%0d] got %h want %h",
                         i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_jdrain();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 1, 64'h2000, 0, 0, 0, 1, 0));
        ex.push_back(E(2'b01, 1, 0, 64'h2000, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 1, 0));
        ex.push_back(E(2'b01, 1, 0, 64'h2000, 0));
        st.push_back(S(0, 0, 64'h0, 0, 0, 0, 1, 1));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        st.push_back(S(1, 0, 64'h0, 0, 0, 0, 0, 1));
        ex.push_back(E(2'b00, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL reset_mid_jdrain[%0d] got %h want %h",
                         i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, exp_o;
        st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b11, 0, 0, 64'h0, 0));
        for (int c = 1; c < TO; c++) begin
            st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
            ex.push_back(E(2'b11, 0, 0, 64'h0, 0));
        end
        st.push_back(S(1, 0, 64'h0, 0, 1, 0, 0, 0));
        ex.push_back(E(2'b00, 1, 0, 64'h0, 1));
        st.push_back(S(1, 0, 64'h0, 1, 0, 0, 0, 0));
        ex.push_back(E(2'b10, 0, 0, 64'h0, 0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            @(negedge clk);
            got   = observe();
            exp_o = sb.pop_front();
            ntests++;
            if (got !== exp_o) begin
                nfail++;
                $display("FAIL timeout[%0d] got %h want %h", i, got, exp_o);
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        apply(S(0, 0, 64'h0, 0, 0, 0, 0, 0), E(2'b00, 0, 0, 64'h0, 0));
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_jump_conflict();
        test_jump_busy();
        test_back_to_back();
        test_reset_mid_wait();
        test_reset_mid_jdrain();
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
